// File: rtl/mips_muldiv_pkg.sv
// Shared types for the MIPS iterative multiply/divide unit.
// Op encodings, FSM states and the default datapath width.
package mips_muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between execute stage and muldiv unit.
// master drives operands and MTHI/MTLO; slave returns HI/LO.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B,
    output hi_we, lo_we, wr_data,
    input  busy, done, div_by_zero,
    input  HI, LO
  );

  modport slave (
    input  start, op, A, B,
    input  hi_we, lo_we, wr_data,
    output busy, done, div_by_zero,
    output HI, LO
  );

endinterface

// File: rtl/mips_muldiv_step.sv
// One iteration of the muldiv datapath.
// mode=0: shift-add multiply, mode=1: restoring divide.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             ge;

  // Multiply: add multiplicand on LSB, shift right with carry.
  // Divide: shift in next dividend bit, subtract if it fits.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    if (acc_i[0])
      sum = sum + {1'b0, opnd};
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    ge     = (rem_sh >= {1'b0, opnd});
    trial  = rem_sh[WIDTH-1:0] - opnd;
    if (mode)
      acc_o = {ge ? trial : rem_sh[WIDTH-1:0],
               acc_i[WIDTH-2:0], ge};
    else
      acc_o = {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// One bit per cycle, sign fix-up in a final cycle.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic       CLK,
  input logic       RESET,
  mips_muldiv_if.slave bus
);

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_n, prod_n;
  logic [WIDTH-1:0]   opnd, hi_q, lo_q;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               is_div, neg_p, neg_r, dbz;
  logic               a_sgn, b_sgn;
  logic               op_div, op_sig, b_zero;
  logic               busy_c, done_c;
  op_e                op_in;

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode  (is_div),
    .acc_i (acc),
    .opnd  (opnd),
    .acc_o (acc_n)
  );

  // Decode the incoming op and form operand magnitudes.
  always_comb begin
    op_in  = op_e'(bus.op);
    op_div = (op_in == OP_DIV) || (op_in == OP_DIVU);
    op_sig = (op_in == OP_MULT) || (op_in == OP_DIV);
    a_sgn  = op_sig & bus.A[WIDTH-1];
    b_sgn  = op_sig & bus.B[WIDTH-1];
    a_mag  = a_sgn ? -bus.A : bus.A;
    b_mag  = b_sgn ? -bus.B : bus.B;
    b_zero = (bus.B == '0);
  end

  // Sign fix-up of the raw magnitude result.
  always_comb begin
    prod_n = -acc;
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (is_div) begin
      if (neg_p) fix_lo = -acc[WIDTH-1:0];
      if (neg_r) fix_hi = -acc[2*WIDTH-1:WIDTH];
    end else if (neg_p) begin
      {fix_hi, fix_lo} = prod_n;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_n = state;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_n = (op_div && b_zero) ? DONE : CALC;
      end
      CALC: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1))
          state_n = FIX;
      end
      FIX: begin
        busy_c  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath, counter, HI/LO and sticky flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            is_div <= op_div;
            neg_p  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn;
            dbz    <= op_div && b_zero;
            if (op_div) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
              if (b_zero) begin
                hi_q <= bus.A;
                lo_q <= '1;
              end
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.wr_data;
            if (bus.lo_we) lo_q <= bus.wr_data;
          end
        end
        CALC: begin
          acc <= acc_n;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.div_by_zero = dbz;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at WIDTH 32 and 8.
// Vector table plus hand sequences for handshake corners.
module tb_mips_muldiv_unit;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  mips_muldiv_if #(.WIDTH(32)) bus32 ();
  mips_muldiv_if #(.WIDTH(8))  bus8 ();

  mips_muldiv_unit #(.WIDTH(32)) u32 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus32)
  );

  mips_muldiv_unit #(.WIDTH(8)) u8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        dbz;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run32(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int lat,
                       output int nbusy,
                       output logic [31:0] hi,
                       output logic [31:0] lo,
                       output logic dbz);
    @(negedge CLK);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.A     = a;
    bus32.B     = b;
    lat = 0; nbusy = 0;
    hi = '0; lo = '0; dbz = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      bus32.start = 1'b0;
      if (bus32.busy) nbusy++;
      if (bus32.done) begin
        lat = k;
        hi  = bus32.HI;
        lo  = bus32.LO;
        dbz = bus32.div_by_zero;
        break;
      end
    end
  endtask

  task automatic run8(input logic [1:0] op,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      output int lat,
                      output logic [7:0] hi,
                      output logic [7:0] lo);
    @(negedge CLK);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.A     = a;
    bus8.B     = b;
    lat = 0; hi = '0; lo = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      bus8.start = 1'b0;
      if (bus8.done) begin
        lat = k;
        hi  = bus8.HI;
        lo  = bus8.LO;
        break;
      end
    end
  endtask

  initial begin
    int          lat, nbusy, ndone;
    logic [31:0] hi, lo;
    logic [7:0]  hi8, lo8;
    logic        dbz;
    checks = 0;
    errors = 0;

    tv[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 34, 1'b0};
    tv[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005,
               32'hFFFFFFFF, 32'hFFFFFFF1, 34, 1'b0};
    tv[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002,
               32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0};
    tv[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 34, 1'b0};
    tv[4]  = '{2'd3, 32'd13, 32'd0,
               32'd13, 32'hFFFFFFFF, 1, 1'b1};
    tv[5]  = '{2'd3, 32'd13, 32'd4,
               32'd1, 32'd3, 34, 1'b0};
    tv[6]  = '{2'd0, 32'd7, 32'hFFFFFFFA,
               32'hFFFFFFFF, 32'hFFFFFFD6, 34, 1'b0};
    tv[7]  = '{2'd2, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD, 34, 1'b0};
    tv[8]  = '{2'd1, 32'h00010000, 32'h00010000,
               32'd1, 32'd0, 34, 1'b0};
    tv[9]  = '{2'd3, 32'hFFFFFFFF, 32'd1,
               32'd0, 32'hFFFFFFFF, 34, 1'b0};
    tv[10] = '{2'd2, 32'hFFFFFFF8, 32'hFFFFFFFD,
               32'hFFFFFFFE, 32'd2, 34, 1'b0};
    tv[11] = '{2'd0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'd0, 34, 1'b0};
    tv[12] = '{2'd2, 32'd5, 32'd0,
               32'd5, 32'hFFFFFFFF, 1, 1'b1};

    bus32.start = 0; bus32.op = 0; bus32.A = 0; bus32.B = 0;
    bus32.hi_we = 0; bus32.lo_we = 0; bus32.wr_data = 0;
    bus8.start = 0; bus8.op = 0; bus8.A = 0; bus8.B = 0;
    bus8.hi_we = 0; bus8.lo_we = 0; bus8.wr_data = 0;

    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(bus32.busy), 64'd0);
    chk("rst_done", 64'(bus32.done), 64'd0);
    chk("rst_dbz", 64'(bus32.div_by_zero), 64'd0);
    chk("rst_hi", 64'(bus32.HI), 64'd0);
    chk("rst_lo", 64'(bus32.LO), 64'd0);
    chk("rst_busy8", 64'(bus8.busy), 64'd0);
    RESET = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run32(tv[i].op, tv[i].a, tv[i].b,
            lat, nbusy, hi, lo, dbz);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(nbusy),
          64'(tv[i].lat - 1));
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(tv[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(tv[i].lo));
      chk($sformatf("v%0d_dbz", i), 64'(dbz), 64'(tv[i].dbz));
    end

    // second start and MTHI while busy are ignored
    @(negedge CLK);
    bus32.start = 1'b1; bus32.op = 2'd1;
    bus32.A = 32'd3; bus32.B = 32'd4;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      bus32.start = 1'b0;
      bus32.hi_we = 1'b0;
      if (k == 5) begin
        bus32.start = 1'b1; bus32.op = 2'd3;
        bus32.A = 32'd100; bus32.B = 32'd7;
        bus32.hi_we = 1'b1; bus32.wr_data = 32'h1234;
      end
      if (k == 10) begin
        chk("calc_hi_hold", 64'(bus32.HI), 64'd5);
        chk("calc_lo_hold", 64'(bus32.LO), 64'hFFFFFFFF);
      end
      if (bus32.done) begin
        lat = k; hi = bus32.HI; lo = bus32.LO;
        break;
      end
    end
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_hi", 64'(hi), 64'd0);
    chk("ign_lo", 64'(lo), 64'd12);

    // MTHI in IDLE, then MTHI+MTLO together
    @(negedge CLK);
    bus32.hi_we = 1'b1; bus32.wr_data = 32'h1234;
    @(negedge CLK);
    bus32.hi_we = 1'b0;
    chk("mthi", 64'(bus32.HI), 64'h1234);
    chk("mthi_lo", 64'(bus32.LO), 64'd12);
    bus32.hi_we = 1'b1; bus32.lo_we = 1'b1;
    bus32.wr_data = 32'hABCD;
    @(negedge CLK);
    bus32.hi_we = 1'b0; bus32.lo_we = 1'b0;
    chk("both_hi", 64'(bus32.HI), 64'hABCD);
    chk("both_lo", 64'(bus32.LO), 64'hABCD);

    // start wins over a simultaneous MTLO
    bus32.start = 1'b1; bus32.op = 2'd1;
    bus32.A = 32'd2; bus32.B = 32'd3;
    bus32.lo_we = 1'b1; bus32.wr_data = 32'h5555;
    @(negedge CLK);
    bus32.start = 1'b0; bus32.lo_we = 1'b0;
    chk("drop_lo", 64'(bus32.LO), 64'hABCD);
    lat = 0;
    for (int k = 2; k <= 200; k++) begin
      @(negedge CLK);
      if (bus32.done) begin
        lat = k; lo = bus32.LO;
        break;
      end
    end
    chk("drop_lat", 64'(lat), 64'd34);
    chk("drop_res", 64'(lo), 64'd6);

    // reset in the middle of CALC discards the result
    @(negedge CLK);
    bus32.start = 1'b1; bus32.op = 2'd1;
    bus32.A = 32'hFFFFFFFF; bus32.B = 32'hFFFFFFFF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      bus32.start = 1'b0;
    end
    chk("pre_rst_busy", 64'(bus32.busy), 64'd1);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    chk("mid_rst_busy", 64'(bus32.busy), 64'd0);
    chk("mid_rst_hi", 64'(bus32.HI), 64'd0);
    chk("mid_rst_lo", 64'(bus32.LO), 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus32.done) ndone++;
    end
    chk("mid_rst_nodone", 64'(ndone), 64'd0);

    // narrow instance
    run8(2'd1, 8'hFF, 8'hFF, lat, hi8, lo8);
    chk("w8_mulu_lat", 64'(lat), 64'd10);
    chk("w8_mulu_hi", 64'(hi8), 64'hFE);
    chk("w8_mulu_lo", 64'(lo8), 64'h01);
    run8(2'd2, 8'hF9, 8'h02, lat, hi8, lo8);
    chk("w8_div_lat", 64'(lat), 64'd10);
    chk("w8_div_hi", 64'(hi8), 64'hFF);
    chk("w8_div_lo", 64'(lo8), 64'hFD);
    run8(2'd3, 8'd13, 8'd0, lat, hi8, lo8);
    chk("w8_dz_lat", 64'(lat), 64'd1);
    chk("w8_dz_hi", 64'(hi8), 64'd13);
    chk("w8_dz_lo", 64'(lo8), 64'hFF);
    chk("w8_dz_flag", 64'(bus8.div_by_zero), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
